// File: rtl/unsaved_nios2_oci_dct_pkg.sv
// Shared constants and state type for the OCI debug-capture-trace buffer controller.
package unsaved_nios2_oci_dct_pkg;

  localparam int FRAG_W = 2;
  localparam int SLOTS  = 15;
  localparam int BUF_W  = FRAG_W * SLOTS;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } dct_state_t;

endpackage

// File: rtl/unsaved_nios2_oci_dct_packer.sv
// Packing buffer and slot counter; exposes post-update values so the FSM
// can decide on the effective count of the current cycle.
module unsaved_nios2_oci_dct_packer
  import unsaved_nios2_oci_dct_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [FRAG_W-1:0] wr_data,
  input  logic              clr,
  output logic [BUF_W-1:0]  buffer,
  output logic [CNT_W-1:0]  count,
  output logic [BUF_W-1:0]  buf_next,
  output logic [CNT_W-1:0]  count_next
);

  always_comb begin
    buf_next   = buffer;
    count_next = count;
    if (clr) begin
      buf_next   = '0;
      count_next = '0;
    end else if (wr_en && (count < CNT_W'(SLOTS))) begin
      buf_next[int'(count) * FRAG_W +: FRAG_W] = wr_data;
      count_next = count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buffer <= '0;
      count  <= '0;
    end else begin
      buffer <= buf_next;
      count  <= count_next;
    end
  end

endmodule

// File: rtl/unsaved_nios2_oci_dct_ctrl.sv
// DCT buffer controller: accepts trace fragments, emits full/flushed buffers
// over valid/ready and sequences the end-of-test flush.
module unsaved_nios2_oci_dct_ctrl
  import unsaved_nios2_oci_dct_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              trc_on,
  input  logic              frag_valid,
  input  logic [FRAG_W-1:0] frag_data,
  output logic              frag_ready,
  input  logic              flush_req,
  input  logic              test_ending,
  output logic              out_valid,
  output logic [BUF_W-1:0]  out_data,
  output logic [CNT_W-1:0]  out_count,
  input  logic              out_ready,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic              test_has_ended
);

  dct_state_t       state, state_next;
  logic             ending_latched;
  logic             end_seen;
  logic             accept;
  logic             handshake;
  logic             load_out;
  logic [BUF_W-1:0] buf_next;
  logic [CNT_W-1:0] count_next;

  // Gated by reset_n so the handshake reads idle while reset is held.
  assign frag_ready     = reset_n & (state == FILL) & trc_on & ~ending_latched;
  assign accept         = frag_valid & frag_ready;
  assign handshake      = (state == EMIT) & out_valid & out_ready;
  assign end_seen       = test_ending | ending_latched;
  assign test_has_ended = (state == DONE);

  unsaved_nios2_oci_dct_packer u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (accept),
    .wr_data    (frag_data),
    .clr        (handshake),
    .buffer     (dct_buffer),
    .count      (dct_count),
    .buf_next   (buf_next),
    .count_next (count_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= FILL;
      ending_latched <= 1'b0;
    end else begin
      state <= state_next;
      if (test_ending) ending_latched <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    load_out   = 1'b0;
    unique case (state)
      FILL: begin
        if ((accept && (count_next == CNT_W'(SLOTS))) ||
            ((flush_req || end_seen) && (count_next != '0))) begin
          state_next = EMIT;
          load_out   = 1'b1;
        end else if (end_seen) begin
          state_next = DONE;
        end
      end
      EMIT:    if (handshake) state_next = end_seen ? DONE : FILL;
      DONE:    state_next = DONE;
      default: state_next = FILL;
    endcase
  end

  // Output register captures the post-accept buffer on entry to EMIT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
    end else if (load_out) begin
      out_valid <= 1'b1;
      out_data  <= buf_next;
      out_count <= count_next;
    end else if (handshake) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_unsaved_nios2_oci_dct_ctrl.sv
// Bench for the DCT buffer controller: fragment-list model checked every cycle
// plus literal expectations for the directed scenarios.
module tb_unsaved_nios2_oci_dct_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        trc_on, frag_valid, flush_req, test_ending, out_ready;
  logic [1:0]  frag_data;
  logic        frag_ready, out_valid, test_has_ended;
  logic [29:0] out_data, dct_buffer;
  logic [3:0]  out_count, dct_count;

  int n_checks = 0;
  int n_fail   = 0;

  unsaved_nios2_oci_dct_ctrl dut (
    .clk(clk), .reset_n(reset_n), .trc_on(trc_on), .frag_valid(frag_valid),
    .frag_data(frag_data), .frag_ready(frag_ready), .flush_req(flush_req),
    .test_ending(test_ending), .out_valid(out_valid), .out_data(out_data),
    .out_count(out_count), .out_ready(out_ready), .dct_buffer(dct_buffer),
    .dct_count(dct_count), .test_has_ended(test_has_ended)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: accepted fragments in order; phase 0 collecting, 1 offering, 2 finished.
  logic [1:0]  q[$];
  int          phase;
  bit          m_end;
  logic [29:0] m_odata;
  int          m_ocount;

  function automatic logic [29:0] pack_q();
    logic [29:0] r = '0;
    foreach (q[i]) r[2*i +: 2] = q[i];
    return r;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete(); phase = 0; m_end = 0; m_odata = '0; m_ocount = 0;
    end else if (phase == 0) begin
      bit acc;
      acc = frag_valid && trc_on && !m_end;
      if (acc) q.push_back(frag_data);
      if (test_ending) m_end = 1;
      if ((acc && q.size() == 15) || ((flush_req || m_end) && q.size() > 0)) begin
        phase = 1; m_odata = pack_q(); m_ocount = q.size();
      end else if (m_end) begin
        phase = 2;
      end
    end else if (phase == 1) begin
      if (test_ending) m_end = 1;
      if (out_ready) begin
        q.delete();
        phase = m_end ? 2 : 0;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("frag_ready", frag_ready, (phase == 0) && trc_on && !m_end);
      chk("out_valid", out_valid, phase == 1);
      if (phase == 1) begin
        chk("out_data", out_data, m_odata);
        chk("out_count", out_count, m_ocount);
      end
      chk("dct_count", dct_count, q.size());
      chk("dct_buffer", dct_buffer, pack_q());
      chk("test_has_ended", test_has_ended, phase == 2);
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [1:0] d);
    frag_valid = 1'b1; frag_data = d;
    cyc();
    frag_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_dct_count", dct_count, 0);
    chk("rst_dct_buffer", dct_buffer, 0);
    chk("rst_frag_ready", frag_ready, 0);
    chk("rst_test_has_ended", test_has_ended, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    reset_n = 1'b1;
    cyc();
  endtask

  initial begin
    reset_n = 1'b0; trc_on = 1'b1; frag_valid = 1'b0; frag_data = 2'b00;
    flush_req = 1'b0; test_ending = 1'b0; out_ready = 1'b1;
    do_reset();

    // Full pack: slot k carries k mod 4.
    for (int k = 0; k < 15; k++) send(2'(k % 4));
    chk("full_valid", out_valid, 1);
    chk("full_data", out_data, 30'h24E4E4E4);
    chk("full_count", out_count, 15);
    cyc();
    chk("full_cleared", dct_count, 0);
    chk("full_resume", frag_ready, 1);

    // Partial flush of three 2'b11 fragments.
    repeat (3) send(2'b11);
    flush_req = 1'b1; cyc(); flush_req = 1'b0;
    chk("part_data", out_data, 30'h3F);
    chk("part_count", out_count, 3);
    cyc();
    flush_req = 1'b1; cyc(); flush_req = 1'b0;
    chk("flush_empty_valid", out_valid, 0);
    cyc();
    chk("flush_empty_valid2", out_valid, 0);

    // Fourth fragment accepted alongside the flush request.
    send(2'b01); send(2'b10); send(2'b11);
    frag_valid = 1'b1; frag_data = 2'b10; flush_req = 1'b1;
    cyc();
    frag_valid = 1'b0; flush_req = 1'b0;
    chk("simul_data", out_data, 30'hB9);
    chk("simul_count", out_count, 4);
    cyc();

    // Trace disabled: buffer retained, then flushed.
    send(2'b01);
    trc_on = 1'b0; frag_valid = 1'b1; frag_data = 2'b11;
    repeat (3) cyc();
    frag_valid = 1'b0;
    chk("trc_off_count", dct_count, 1);
    flush_req = 1'b1; cyc(); flush_req = 1'b0; trc_on = 1'b1;
    chk("trc_off_data", out_data, 30'h1);
    cyc();

    // Backpressure: held for 10 cycles with fragments and flushes offered.
    out_ready = 1'b0;
    send(2'b01); send(2'b01);
    flush_req = 1'b1; cyc(); flush_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      frag_valid = 1'b1; frag_data = 2'b11; flush_req = i[0];
      cyc();
      chk("bp_data", out_data, 30'h5);
      chk("bp_count", out_count, 2);
      chk("bp_ready", frag_ready, 0);
    end
    frag_valid = 1'b0; flush_req = 1'b0; out_ready = 1'b1;
    cyc();
    chk("bp_one_xfer", out_valid, 0);
    repeat (2) cyc();
    chk("bp_no_second", out_valid, 0);

    // Reset while a buffer is pending.
    out_ready = 1'b0;
    send(2'b10);
    flush_req = 1'b1; cyc(); flush_req = 1'b0;
    chk("pre_rst_valid", out_valid, 1);
    do_reset();
    chk("post_rst_count", dct_count, 0);
    chk("post_rst_fill", frag_ready, 1);
    out_ready = 1'b1;

    // End of test with five fragments pending.
    repeat (5) send(2'b10);
    test_ending = 1'b1; cyc();
    chk("end_valid", out_valid, 1);
    chk("end_data", out_data, 30'h2AA);
    chk("end_count", out_count, 5);
    frag_valid = 1'b1;
    cyc();
    chk("end_done", test_has_ended, 1);
    chk("end_ready", frag_ready, 0);
    repeat (3) cyc();
    chk("end_sticky", test_has_ended, 1);
    frag_valid = 1'b0; test_ending = 1'b0;

    // End of test with nothing pending.
    do_reset();
    test_ending = 1'b1; cyc();
    chk("end0_done", test_has_ended, 1);
    chk("end0_valid", out_valid, 0);
    test_ending = 1'b0;
    repeat (3) cyc();
    chk("end0_sticky", test_has_ended, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
